// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler for the multi-core systolic matrix multiplier: walks the C tile space,
// issues one k-step per cycle to the BRAM read ports and queues in-order tile results.
module matmul_tile_scheduler #(
  parameter int WIDTH             = 16,
  parameter int CHUNK_SIZE        = 4,
  parameter int NUM_CORES         = 2,
  parameter int BLOCK_SIZE        = 2,
  parameter int INNER_DIMENSION   = 4,
  parameter int I_OUTER_DIMENSION = 8,
  parameter int W_OUTER_DIMENSION = 6,
  parameter int ADDR_WIDTH_I      = 8,
  parameter int ADDR_WIDTH_W      = 8,
  parameter int OUT_FIFO_DEPTH    = 4,
  parameter int IDX_W             = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  cfg_col_major,
  output logic                                  in_rd_en,
  output logic [ADDR_WIDTH_I-1:0]               in_rd_addr,
  output logic                                  wb_rd_en,
  output logic [ADDR_WIDTH_W-1:0]               wb_rd_addr,
  output logic                                  core_valid,
  output logic                                  core_first,
  output logic                                  core_last,
  input  logic                                  core_res_valid,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] core_res,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] m_data,
  output logic [IDX_W-1:0]                      m_row,
  output logic [IDX_W-1:0]                      m_col,
  output logic                                  m_last,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow
);

  localparam int K_TILES    = INNER_DIMENSION / BLOCK_SIZE;
  localparam int ROW_GROUPS = I_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES);
  localparam int COL_TILES  = W_OUTER_DIMENSION / BLOCK_SIZE;
  localparam int DATA_W     = WIDTH * CHUNK_SIZE * NUM_CORES;
  localparam int PTR_W      = $clog2(OUT_FIFO_DEPTH);
  localparam int CRED_W     = PTR_W + 1;

  localparam logic [IDX_W-1:0]  K_LAST   = IDX_W'(K_TILES - 1);
  localparam logic [IDX_W-1:0]  ROW_LAST = IDX_W'(ROW_GROUPS - 1);
  localparam logic [IDX_W-1:0]  COL_LAST = IDX_W'(COL_TILES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W + 1)'(1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(OUT_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CREDIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_k;
  logic [IDX_W-1:0]    r_row;
  logic [IDX_W-1:0]    r_col;
  logic                r_col_major;
  logic [CRED_W-1:0]   r_outstanding;

  logic                    r_in_rd_en;
  logic [ADDR_WIDTH_I-1:0] r_in_rd_addr;
  logic                    r_wb_rd_en;
  logic [ADDR_WIDTH_W-1:0] r_wb_rd_addr;
  logic                    r_iss_first;
  logic                    r_iss_last;
  logic                    r_core_valid;
  logic                    r_core_first;
  logic                    r_core_last;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_overflow;

  logic [IDX_W-1:0]    r_res_row;
  logic [IDX_W-1:0]    r_res_col;
  logic [DATA_W-1:0]   r_mem_data [OUT_FIFO_DEPTH];
  logic [IDX_W-1:0]    r_mem_row  [OUT_FIFO_DEPTH];
  logic [IDX_W-1:0]    r_mem_col  [OUT_FIFO_DEPTH];
  logic                r_mem_last [OUT_FIFO_DEPTH];
  logic [PTR_W:0]      r_wr_ptr;
  logic [PTR_W:0]      r_rd_ptr;

  logic                    w_start_ok;
  logic                    w_in_issue;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_credit_ok;
  logic                    w_do_issue;
  logic                    w_issue_new;
  logic                    w_step_last;
  logic                    w_tile_last;
  logic                    w_final_pop;
  logic                    w_res_last;
  logic                    w_cur_cm;
  logic [IDX_W-1:0]        w_cur_k;
  logic [IDX_W-1:0]        w_cur_row;
  logic [IDX_W-1:0]        w_cur_col;
  logic [IDX_W-1:0]        w_nxt_k;
  logic [IDX_W-1:0]        w_nxt_row;
  logic [IDX_W-1:0]        w_nxt_col;
  logic [IDX_W-1:0]        w_res_nxt_row;
  logic [IDX_W-1:0]        w_res_nxt_col;
  logic [ADDR_WIDTH_I-1:0] w_in_addr;
  logic [ADDR_WIDTH_W-1:0] w_wb_addr;

  assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_in_issue  = (r_state == S_ISSUE) || (r_state == S_WAIT_CREDIT);
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop       = !w_empty && m_ready;
  assign w_push      = core_res_valid && (!w_full || w_pop);
  assign w_final_pop = w_pop && m_last && (r_state == S_DRAIN);

  // An accepted start issues tile 0, k 0 immediately, so the walk position is forced to zero.
  assign w_cur_k     = w_start_ok ? '0 : r_k;
  assign w_cur_row   = w_start_ok ? '0 : r_row;
  assign w_cur_col   = w_start_ok ? '0 : r_col;
  assign w_cur_cm    = w_start_ok ? cfg_col_major : r_col_major;

  assign w_credit_ok = (r_outstanding < CRED_MAX) || w_pop;
  assign w_do_issue  = w_start_ok || (w_in_issue && ((w_cur_k != '0) || w_credit_ok));
  assign w_issue_new = w_do_issue && (w_cur_k == '0);
  assign w_step_last = (w_cur_k == K_LAST);
  assign w_tile_last = (w_cur_row == ROW_LAST) && (w_cur_col == COL_LAST);

  assign w_in_addr   = ADDR_WIDTH_I'(w_cur_k) + ADDR_WIDTH_I'(K_TILES * w_cur_row);
  assign w_wb_addr   = ADDR_WIDTH_W'(w_cur_k) + ADDR_WIDTH_W'(K_TILES * w_cur_col);

  always_comb begin
    w_nxt_k   = w_cur_k + IDX_ONE;
    w_nxt_row = w_cur_row;
    w_nxt_col = w_cur_col;
    if (w_step_last) begin
      w_nxt_k = '0;
      if (!w_cur_cm) begin
        if (w_cur_col == COL_LAST) begin
          w_nxt_col = '0;
          w_nxt_row = w_cur_row + IDX_ONE;
        end else begin
          w_nxt_col = w_cur_col + IDX_ONE;
        end
      end else begin
        if (w_cur_row == ROW_LAST) begin
          w_nxt_row = '0;
          w_nxt_col = w_cur_col + IDX_ONE;
        end else begin
          w_nxt_row = w_cur_row + IDX_ONE;
        end
      end
    end
  end

  // Result tags replay the issue order, since the cores return tiles in the order issued.
  always_comb begin
    w_res_nxt_row = r_res_row;
    w_res_nxt_col = r_res_col;
    if (!r_col_major) begin
      if (r_res_col == COL_LAST) begin
        w_res_nxt_col = '0;
        w_res_nxt_row = r_res_row + IDX_ONE;
      end else begin
        w_res_nxt_col = r_res_col + IDX_ONE;
      end
    end else begin
      if (r_res_row == ROW_LAST) begin
        w_res_nxt_row = '0;
        w_res_nxt_col = r_res_col + IDX_ONE;
      end else begin
        w_res_nxt_row = r_res_row + IDX_ONE;
      end
    end
  end

  assign w_res_last = (r_res_row == ROW_LAST) && (r_res_col == COL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_col_major   <= 1'b0;
      r_outstanding <= '0;
      r_in_rd_en    <= 1'b0;
      r_in_rd_addr  <= '0;
      r_wb_rd_en    <= 1'b0;
      r_wb_rd_addr  <= '0;
      r_iss_first   <= 1'b0;
      r_iss_last    <= 1'b0;
      r_core_valid  <= 1'b0;
      r_core_first  <= 1'b0;
      r_core_last   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_in_rd_en    <= w_do_issue;
      r_wb_rd_en    <= w_do_issue;
      r_in_rd_addr  <= w_do_issue ? w_in_addr : '0;
      r_wb_rd_addr  <= w_do_issue ? w_wb_addr : '0;
      r_iss_first   <= w_do_issue && (w_cur_k == '0);
      r_iss_last    <= w_do_issue && w_step_last;
      r_core_valid  <= r_in_rd_en;
      r_core_first  <= r_iss_first;
      r_core_last   <= r_iss_last;
      r_outstanding <= r_outstanding + CRED_W'(w_issue_new) - CRED_W'(w_pop);

      if (w_do_issue) begin
        r_k         <= w_nxt_k;
        r_row       <= w_nxt_row;
        r_col       <= w_nxt_col;
        r_col_major <= w_cur_cm;
      end

      case (r_state)
        S_IDLE, S_DONE, S_ISSUE, S_WAIT_CREDIT: begin
          if (w_start_ok || w_in_issue) begin
            if (w_do_issue && w_step_last && w_tile_last)
              r_state <= S_DRAIN;
            else if (w_do_issue)
              r_state <= S_ISSUE;
            else
              r_state <= S_WAIT_CREDIT;
          end
        end
        S_DRAIN: begin
          if (w_final_pop)
            r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_start_ok) begin
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (w_final_pop) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        if (core_res_valid && w_full && !w_pop)
          r_overflow <= 1'b1;
      end
    end
  end

  // A full push with a simultaneous pop reuses the slot being vacated; the head slot is never
  // written while it is still waiting, so the outputs hold during back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_res_row <= '0;
      r_res_col <= '0;
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_row[i]  <= '0;
        r_mem_col[i]  <= '0;
        r_mem_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr[PTR_W-1:0]] <= core_res;
        r_mem_row[r_wr_ptr[PTR_W-1:0]]  <= r_res_row;
        r_mem_col[r_wr_ptr[PTR_W-1:0]]  <= r_res_col;
        r_mem_last[r_wr_ptr[PTR_W-1:0]] <= w_res_last;
        r_wr_ptr                        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_start_ok) begin
        r_res_row <= '0;
        r_res_col <= '0;
      end else if (w_push) begin
        r_res_row <= w_res_nxt_row;
        r_res_col <= w_res_nxt_col;
      end
    end
  end

  assign in_rd_en   = r_in_rd_en;
  assign in_rd_addr = r_in_rd_addr;
  assign wb_rd_en   = r_wb_rd_en;
  assign wb_rd_addr = r_wb_rd_addr;
  assign core_valid = r_core_valid;
  assign core_first = r_core_first;
  assign core_last  = r_core_last;
  assign m_valid    = !w_empty;
  assign m_data     = r_mem_data[r_rd_ptr[PTR_W-1:0]];
  assign m_row      = r_mem_row[r_rd_ptr[PTR_W-1:0]];
  assign m_col      = r_mem_col[r_rd_ptr[PTR_W-1:0]];
  assign m_last     = r_mem_last[r_rd_ptr[PTR_W-1:0]];
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler: table-driven address/pop-order vectors plus
// hand-written sequences for back-pressure, credit stall, overflow and mid-run reset.
module tb_matmul_tile_scheduler;

  localparam int DATA_W = 128;

  typedef struct {
    logic       cm;
    logic [7:0] inA;
    logic [7:0] wbA;
  } readVec_t;

  typedef struct {
    logic cm;
    int   row;
    int   col;
    logic last;
  } popVec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cfgColMajor = 1'b0;
  logic m_ready = 1'b1;

  logic              in_rd_en, wb_rd_en;
  logic [7:0]        in_rd_addr, wb_rd_addr;
  logic              core_valid, core_first, core_last;
  logic              core_res_valid;
  logic [DATA_W-1:0] core_res;
  logic              m_valid, m_last, busy, done, overflow;
  logic [DATA_W-1:0] m_data;
  logic [15:0]       m_row, m_col;

  logic              modelValid = 1'b0;
  logic              manualValid = 1'b0;
  logic [DATA_W-1:0] modelData = '0;
  logic [DATA_W-1:0] manualData = '0;

  assign core_res_valid = modelValid | manualValid;
  assign core_res       = manualValid ? manualData : modelData;

  int checkCount = 0;
  int passCount  = 0;

  readVec_t readTab [24];
  popVec_t  popTab  [12];

  logic [2:0]        hist = '0;
  logic [15:0]       seq = 16'h1000;
  logic [DATA_W-1:0] expQ [$];

  int   popCount = 0;
  int   popRow [8];
  int   popCol [8];
  logic popLast [8];

  always #5 clk = ~clk;

  matmul_tile_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .cfg_col_major(cfgColMajor),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr),
    .core_valid(core_valid), .core_first(core_first), .core_last(core_last),
    .core_res_valid(core_res_valid), .core_res(core_res),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_col(m_col), .m_last(m_last),
    .busy(busy), .done(done), .overflow(overflow)
  );

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Core model: returns a tile result 3 cycles after core_last and records it in the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      hist = '0;
      modelValid = 1'b0;
    end else begin
      modelValid = hist[2];
      if (hist[2]) begin
        modelData = {8{seq}};
        expQ.push_back({8{seq}});
        seq = seq + 16'd1;
      end
      hist = {hist[1:0], core_valid & core_last};
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      checkOutput("popHasExpected", DATA_W'(expQ.size() > 0), 1);
      if (expQ.size() > 0) checkOutput("popData", m_data, expQ.pop_front());
      if (popCount < 8) begin
        popRow[popCount]  = int'(m_row);
        popCol[popCount]  = int'(m_col);
        popLast[popCount] = m_last;
      end
      popCount++;
    end
  end

  task automatic applyStimulus(input logic cm);
    @(posedge clk); #1;
    start = 1'b1;
    cfgColMajor = cm;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busyAfterStart", busy, 1);
    checkOutput("doneClearedOnStart", done, 0);
  endtask

  task automatic checkReads(input int tab, input int from, input int cnt, input bit pokeStart);
    readVec_t v;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      if (pokeStart) start = (i == 4);
      v = readTab[tab*12 + from + i];
      checkOutput($sformatf("rdEn[%0d]", from + i), {in_rd_en, wb_rd_en}, 2'b11);
      checkOutput($sformatf("inAddr[%0d]", from + i), in_rd_addr, v.inA);
      checkOutput($sformatf("wbAddr[%0d]", from + i), wb_rd_addr, v.wbA);
      if (i > 0)
        checkOutput($sformatf("coreStrobes[%0d]", from + i),
                    {core_valid, core_first, core_last},
                    {1'b1, ((from + i - 1) % 2) == 0, ((from + i - 1) % 2) == 1});
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("rdEnAfterBurst", {in_rd_en, wb_rd_en}, 2'b00);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneSeen", done, 1);
    checkOutput("busyAfterDone", busy, 0);
  endtask

  task automatic checkPops(input int tab);
    popVec_t p;
    checkOutput("popCount", popCount, 6);
    for (int i = 0; i < 6; i++) begin
      p = popTab[tab*6 + i];
      if (i < popCount) begin
        checkOutput($sformatf("popRow[%0d]", i), popRow[i], p.row);
        checkOutput($sformatf("popCol[%0d]", i), popCol[i], p.col);
        checkOutput($sformatf("popLast[%0d]", i), popLast[i], p.last);
      end
    end
  endtask

  initial begin
    int inA0 [12] = '{0, 1, 0, 1, 0, 1, 2, 3, 2, 3, 2, 3};
    int wbA0 [12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    int inA1 [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int wbA1 [12] = '{0, 1, 0, 1, 2, 3, 2, 3, 4, 5, 4, 5};
    int row0 [6]  = '{0, 0, 0, 1, 1, 1};
    int col0 [6]  = '{0, 1, 2, 0, 1, 2};
    int row1 [6]  = '{0, 1, 0, 1, 0, 1};
    int col1 [6]  = '{0, 0, 1, 1, 2, 2};
    bit sawRead;

    for (int i = 0; i < 12; i++) begin
      readTab[i]      = '{1'b0, 8'(inA0[i]), 8'(wbA0[i])};
      readTab[12 + i] = '{1'b1, 8'(inA1[i]), 8'(wbA1[i])};
    end
    for (int i = 0; i < 6; i++) begin
      popTab[i]     = '{1'b0, row0[i], col0[i], i == 5};
      popTab[6 + i] = '{1'b1, row1[i], col1[i], i == 5};
    end

    repeat (2) @(negedge clk);
    checkOutput("rstRead", {in_rd_en, wb_rd_en, in_rd_addr, wb_rd_addr}, 0);
    checkOutput("rstStatus", {m_valid, busy, done, overflow, core_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Row-major run with free-flowing consumer.
    popCount = 0;
    applyStimulus(readTab[0].cm);
    checkReads(0, 0, 12, 1'b0);
    waitDone();
    checkPops(0);
    checkOutput("noOverflowA", overflow, 0);

    // Column-major run, with a start pulse during the busy period that must be ignored.
    popCount = 0;
    applyStimulus(readTab[12].cm);
    checkReads(1, 0, 12, 1'b1);
    waitDone();
    checkPops(1);

    // Consumer stalled: exactly four tiles issue before credits run out.
    popCount = 0;
    m_ready = 1'b0;
    applyStimulus(1'b0);
    checkReads(0, 0, 8, 1'b0);
    sawRead = 1'b0;
    repeat (12) begin
      @(negedge clk);
      sawRead |= in_rd_en | wb_rd_en;
    end
    checkOutput("creditStallNoRead", sawRead, 0);
    checkOutput("fifoHeadValid", m_valid, 1);
    checkOutput("noOverflowQueued", overflow, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("holdValid[%0d]", i), m_valid, 1);
      checkOutput($sformatf("holdData[%0d]", i), m_data, expQ[0]);
      checkOutput($sformatf("holdIdx[%0d]", i), {m_row, m_col}, 0);
    end

    // Extra result while full and not popping is dropped and flagged.
    @(posedge clk); #1;
    manualValid = 1'b1;
    manualData = {8{16'hDEAD}};
    @(posedge clk); #1;
    manualValid = 1'b0;
    @(negedge clk);
    checkOutput("overflowSet", overflow, 1);
    checkOutput("headAfterOverflow", m_data, expQ[0]);

    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("resumeGap", in_rd_en, 0);
    checkReads(0, 8, 4, 1'b0);
    waitDone();
    checkPops(0);
    checkOutput("overflowSticky", overflow, 1);

    // Reset in the middle of a run.
    popCount = 0;
    applyStimulus(1'b0);
    checkOutput("overflowClearedOnStart", overflow, 0);
    repeat (5) @(negedge clk);
    checkOutput("preRstRead", in_rd_en, 1);
    rst = 1'b1;
    #1;
    checkOutput("midRstRead", {in_rd_en, wb_rd_en, in_rd_addr, wb_rd_addr}, 0);
    checkOutput("midRstCore", {core_valid, core_first, core_last}, 0);
    checkOutput("midRstFifo", {m_valid, m_last, m_row, m_col}, 0);
    checkOutput("midRstData", m_data, 0);
    checkOutput("midRstStatus", {busy, done, overflow}, 0);
    repeat (2) @(negedge clk);
    expQ.delete();
    popCount = 0;
    #1;
    rst = 1'b0;

    applyStimulus(1'b0);
    checkReads(0, 0, 12, 1'b0);
    waitDone();
    checkPops(0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
